seq_mul_iter: RTL and testbench

Iterative shift-add multiplier: the parametrised successor of the single-cycle combinational multiplier in the sequential ALU datapath. It accepts one operand pair per transaction over a valid/ready handshake and supports per-operation signed or unsigned mode. It retires one multiplier bit per clock and returns the full double-width product plus an overflow flag. It sits behind the ALU operand registers and trades latency for a small area footprint at wide operand widths.

---
 rtl/seq_mul_iter_if.sv | 26 ++
 rtl/seq_mul_iter.sv | 111 +++++++++++
 tb/tb_seq_mul_iter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seq_mul_iter_if.sv
// Operand/result handshake bundle for the iterative multiplier.
// master: upstream/downstream side; slave: the multiplier itself.
interface seq_mul_iter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_data_a;
  logic [WIDTH-1:0] i_data_b;
  logic             i_signed;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_data_hi;
  logic             o_overflow;
  logic             o_valid;
  logic             i_ready;

  modport master (
    output i_data_a, i_data_b, i_signed, i_valid, i_ready,
    input  o_ready, o_data, o_data_hi, o_overflow, o_valid
  );

  modport slave (
    input  i_data_a, i_data_b, i_signed, i_valid, i_ready,
    output o_ready, o_data, o_data_hi, o_overflow, o_valid
  );
endinterface

// File: rtl/seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed via
// magnitude multiply plus final negation, full double-width product and overflow.
module seq_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_mul_iter_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               neg_reg;
  logic               signed_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [WIDTH-1:0]   data_hi_reg;
  logic               ovf_reg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] product;
  logic               last_bit;
  logic               ovf_next;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact when read as unsigned.
  assign mag_a = (bus.i_signed && bus.i_data_a[WIDTH-1]) ? -bus.i_data_a : bus.i_data_a;
  assign mag_b = (bus.i_signed && bus.i_data_b[WIDTH-1]) ? -bus.i_data_b : bus.i_data_b;

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign product  = neg_reg ? -acc_sum : acc_sum;
  assign ovf_next = signed_reg
                  ? (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}})
                  : (product[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.i_valid) state_next = BUSY;
      BUSY:    if (last_bit)    state_next = DONE;
      DONE:    if (bus.i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    bus.o_ready = (state_reg == IDLE);
    bus.o_valid = (state_reg == DONE);
  end

  assign bus.o_data     = data_reg;
  assign bus.o_data_hi  = data_hi_reg;
  assign bus.o_overflow = ovf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg   <= '0;
      acc_reg     <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      signed_reg  <= 1'b0;
      data_reg    <= '0;
      data_hi_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_valid) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
            neg_reg    <= bus.i_signed & (bus.i_data_a[WIDTH-1] ^ bus.i_data_b[WIDTH-1]);
            signed_reg <= bus.i_signed;
            cnt_reg    <= '0;
            acc_reg    <= '0;
          end
        end
        BUSY: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (last_bit) begin
            data_reg    <= product[WIDTH-1:0];
            data_hi_reg <= product[2*WIDTH-1:WIDTH];
            ovf_reg     <= ovf_next;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_iter.sv
// Directed bench for seq_mul_iter (WIDTH=8) with a queue-based scoreboard.
module tb_seq_mul_iter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_mul_iter_if #(.WIDTH(W)) bus ();

  seq_mul_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endfunction

  // Monitor: a transfer happens on the edge following a low phase with valid && ready.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got=result want=none lo=%02h hi=%02h", bus.o_data, bus.o_data_hi);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_lo"},  64'(bus.o_data),     64'(mon_e.lo));
        chk({mon_e.tag, "_hi"},  64'(bus.o_data_hi),  64'(mon_e.hi));
        chk({mon_e.tag, "_ovf"}, 64'(bus.o_overflow), 64'(mon_e.ovf));
        $display("txn %s: product=%02h%02h ovf=%0d", mon_e.tag, bus.o_data_hi, bus.o_data, bus.o_overflow);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(string tag);
    int k;
    for (k = 0; k < 50 && !bus.o_ready; k++) step();
    if (!bus.o_ready) chk({tag, "_ready_timeout"}, 64'(bus.o_ready), 64'd1);
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic s);
    bus.i_data_a = a;
    bus.i_data_b = b;
    bus.i_signed = s;
    bus.i_valid  = 1'b1;
    step();
    bus.i_valid  = 1'b0;
  endtask

  task automatic run_op(string tag, logic [W-1:0] a, logic [W-1:0] b, logic s,
                        logic [W-1:0] lo, logic [W-1:0] hi, logic ovf);
    exp_t e;
    int n;
    wait_ready(tag);
    e.lo = lo; e.hi = hi; e.ovf = ovf; e.tag = tag;
    sb.push_back(e);
    issue(a, b, s);
    n = 0;
    while (!bus.o_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(W));
    step();
    chk({tag, "_ready_after"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    int n;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    bus.i_signed = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.o_ready),    64'd1);
    chk("rst_valid", 64'(bus.o_valid),    64'd0);
    chk("rst_data",  64'({bus.o_data_hi, bus.o_data}), 64'd0);
    chk("rst_ovf",   64'(bus.o_overflow), 64'd0);
    #11 rst_n = 1'b1;
    step();

    run_op("u13x11",   8'd13,  8'd11,  1'b0, 8'h8F, 8'h00, 1'b0);
    run_op("s13x11",   8'd13,  8'd11,  1'b1, 8'h8F, 8'h00, 1'b1);
    run_op("sm3x5",    8'hFD,  8'h05,  1'b1, 8'hF1, 8'hFF, 1'b0);
    run_op("s80x80",   8'h80,  8'h80,  1'b1, 8'h00, 8'h40, 1'b1);
    run_op("uFFxFF",   8'hFF,  8'hFF,  1'b0, 8'h01, 8'hFE, 1'b1);
    run_op("sFFxFF",   8'hFF,  8'hFF,  1'b1, 8'h01, 8'h00, 1'b0);
    run_op("s7Fxm1",   8'h7F,  8'hFF,  1'b1, 8'h81, 8'hFF, 1'b0);
    run_op("u10x10",   8'h10,  8'h10,  1'b0, 8'h00, 8'h01, 1'b1);
    run_op("u0x5A",    8'h00,  8'h5A,  1'b0, 8'h00, 8'h00, 1'b0);

    // Backpressure: result must hold and new requests be ignored while stalled.
    bus.i_ready = 1'b0;
    wait_ready("bp");
    begin
      exp_t e;
      e.lo = 8'h8F; e.hi = 8'h00; e.ovf = 1'b0; e.tag = "bp_u13x11";
      sb.push_back(e);
    end
    issue(8'd13, 8'd11, 1'b0);
    n = 0;
    while (!bus.o_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_latency", 64'(n), 64'(W));
    for (int k = 0; k < 3; k++) begin
      bus.i_data_a = 8'hA5 ^ 8'(k);
      bus.i_data_b = 8'h3C ^ 8'(k * 3);
      bus.i_signed = k[0];
      bus.i_valid  = 1'b1;
      step();
      chk("bp_hold_valid", 64'(bus.o_valid), 64'd1);
      chk("bp_hold_ready", 64'(bus.o_ready), 64'd0);
      chk("bp_hold_data",  64'({bus.o_overflow, bus.o_data_hi, bus.o_data}), 64'h0_00_8F);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    step();
    chk("bp_release_ready", 64'(bus.o_ready), 64'd1);
    chk("bp_release_valid", 64'(bus.o_valid), 64'd0);
    chk("bp_keep_data",     64'({bus.o_data_hi, bus.o_data}), 64'h008F);
    n = 0;
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (bus.o_valid) n++;
    end
    chk("bp_ignored_req", 64'(n), 64'd0);

    // Reset at the 4th BUSY cycle aborts without a clock edge.
    wait_ready("rst_mid");
    issue(8'd13, 8'd11, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 64'(bus.o_valid), 64'd0);
    chk("rstmid_ready", 64'(bus.o_ready), 64'd1);
    chk("rstmid_data",  64'({bus.o_data_hi, bus.o_data}), 64'd0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    run_op("u2x3", 8'd2, 8'd3, 1'b0, 8'h06, 8'h00, 1'b0);

    repeat (4) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
